// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter_pkg
//  Description : Shared definitions for the period meter and its companion
//                divider bench. This file holds the FSM state encoding and
//                the default counter width and expected divide ratio.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package period_meter_pkg;

    // Measurement FSM states, with an explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for the first rising edge
        ST_MEAS = 2'd1,   // counting between rising edges
        ST_TMO  = 2'd2    // no rising edge within the counter range
    } state_t;

    localparam int c_DEF_CNT_W   = 16;
    localparam int c_DEF_EXP_DIV = 100;

endpackage : period_meter_pkg
`default_nettype wire

// File: rtl/period_meter_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Two-flop synchronizer for an asynchronous input, followed by
//                one delay flop that is used for edge detection.
//  Ports       : iClk_in - clock
//                iRst    - synchronous active-low reset
//                iSig    - asynchronous input
//                oLevel  - synchronized level
//                oRise   - synchronized level is 1 and delayed level is 0
//                oFall   - synchronized level is 0 and delayed level is 1
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  logic iClk_in,
    input  logic iRst,
    input  logic iSig,
    output logic oLevel,
    output logic oRise,
    output logic oFall
);

    logic r_meta;    // first synchronizer stage (may go metastable)
    logic r_sync;    // second synchronizer stage
    logic r_dly;     // synchronized level delayed by one cycle

    always_ff @(posedge iClk_in) begin
        if (!iRst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= iSig;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign oLevel = r_sync;
    assign oRise  =  r_sync & ~r_dly;
    assign oFall  = ~r_sync &  r_dly;

endmodule : sync_edge
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter
//  Description : Measures the period and the high time of an asynchronous
//                signal in clock cycles. It flags the period when it equals
//                an expected divide ratio. It reports a timeout when no
//                rising edge arrives within the counter range.
//  Ports       : iClk_in  - clock
//                iRst     - synchronous active-low reset
//                iSig     - asynchronous measured signal
//                oPeriod  - cycles between the last two rising edges
//                oHigh    - cycles high within that period
//                oValid   - one-cycle pulse when oPeriod/oHigh update
//                oDivOk   - level, the last period equals EXP_DIV
//                oTimeout - level, no rising edge within 2^CNT_W-1 cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module period_meter #(
    parameter int CNT_W   = period_meter_pkg::c_DEF_CNT_W,
    parameter int EXP_DIV = period_meter_pkg::c_DEF_EXP_DIV
) (
    input  logic             iClk_in,
    input  logic             iRst,
    input  logic             iSig,
    output logic [CNT_W-1:0] oPeriod,
    output logic [CNT_W-1:0] oHigh,
    output logic             oValid,
    output logic             oDivOk,
    output logic             oTimeout
);

    import period_meter_pkg::*;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   c_EXP     = (CNT_W+1)'(EXP_DIV);

    logic w_level;
    logic w_rise;
    logic w_fall;

    sync_edge u_sync_edge (
        .iClk_in (iClk_in),
        .iRst    (iRst),
        .iSig    (iSig),
        .oLevel  (w_level),
        .oRise   (w_rise),
        .oFall   (w_fall)
    );

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;     // cycles since the last rise
    logic [CNT_W-1:0] r_hcnt;    // high cycles since the last rise
    logic [CNT_W-1:0] r_hhold;   // high time captured at the last fall

    // The period is computed one bit wider. A rise that arrives when the
    // counter is at its maximum would give 2^CNT_W. That value is clamped to
    // all-ones, so the reported period saturates and does not wrap to 0.
    logic [CNT_W:0]   w_cntExt;
    logic [CNT_W-1:0] w_periodSat;

    assign w_cntExt    = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_periodSat = w_cntExt[CNT_W] ? c_CNT_MAX : w_cntExt[CNT_W-1:0];

    always_ff @(posedge iClk_in) begin
        if (!iRst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hcnt   <= '0;
            r_hhold  <= '0;
            oPeriod  <= '0;
            oHigh    <= '0;
            oValid   <= 1'b0;
            oDivOk   <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            oValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_MEAS;
                        r_cnt   <= '0;
                        r_hcnt  <= '0;
                        r_hhold <= '0;
                    end
                end

                ST_MEAS: begin
                    // A rise takes priority over the timeout in the same cycle.
                    if (w_rise) begin
                        oPeriod <= w_periodSat;
                        oHigh   <= r_hhold;
                        oValid  <= 1'b1;
                        oDivOk  <= (w_cntExt == c_EXP);
                        r_cnt   <= '0;
                        r_hcnt  <= '0;
                        r_hhold <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        // Counter saturates here. The outputs keep their last
                        // measurement.
                        r_state  <= ST_TMO;
                        oTimeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                        if (w_level) begin
                            r_hcnt <= r_hcnt + c_ONE;
                        end
                        // The fall cycle itself is low. Adding 1 counts the
                        // rise cycle, which hcnt skipped when it cleared.
                        if (w_fall) begin
                            r_hhold <= r_hcnt + c_ONE;
                        end
                    end
                end

                ST_TMO: begin
                    if (w_rise) begin
                        r_state  <= ST_MEAS;
                        r_cnt    <= '0;
                        r_hcnt   <= '0;
                        r_hhold  <= '0;
                        oTimeout <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : period_meter
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_period_meter
//  Description : Directed self-checking bench for period_meter with an 8-bit
//                counter and an expected divide ratio of 100.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_period_meter;

    localparam int CNT_W   = 8;
    localparam int EXP_DIV = 100;

    logic             clk;
    logic             rstN;
    logic             sig;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             valid;
    logic             divOk;
    logic             timeout;

    period_meter #(
        .CNT_W   (CNT_W),
        .EXP_DIV (EXP_DIV)
    ) dut (
        .iClk_in  (clk),
        .iRst     (rstN),
        .iSig     (sig),
        .oPeriod  (period),
        .oHigh    (high),
        .oValid   (valid),
        .oDivOk   (divOk),
        .oTimeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation of every valid pulse. All values here are read from the DUT.
    // Expected values come from the constants in the initial block.
    int          cyc        = 0;
    int          validCnt   = 0;
    int          dupCnt     = 0;
    int          lastGap    = 0;
    int          lastVCyc   = 0;
    logic        prevValid  = 1'b0;
    logic [31:0] lastPeriod = '0;
    logic [31:0] lastHigh   = '0;
    logic        lastDivOk  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            validCnt   = validCnt + 1;
            lastGap    = cyc - lastVCyc;
            lastVCyc   = cyc;
            lastPeriod = 32'(period);
            lastHigh   = 32'(high);
            lastDivOk  = divOk;
            if (prevValid) dupCnt = dupCnt + 1;
        end
        prevValid = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full period of iSig, with edges driven just after a falling clock
    // edge so that setup is met.
    task automatic sigPeriod(input int hi, input int lo);
        sig = 1'b1;
        repeat (hi) @(negedge clk);
        sig = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    int v0;

    initial begin
        rstN = 1'b0;
        sig  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_period",  32'(period), 0);
        check("rst_high",    32'(high),   0);
        check("rst_valid",   32'(valid),  0);
        check("rst_divok",   32'(divOk),  0);
        check("rst_timeout", 32'(timeout), 0);
        rstN = 1'b1;
        @(negedge clk);

        // Divide-by-100 with 50/50 duty. The first rise only arms the meter.
        v0 = validCnt;
        sigPeriod(50, 50);
        check("div100_first_rise_novalid", 32'(validCnt - v0), 0);
        sigPeriod(50, 50);
        sigPeriod(50, 50);
        sigPeriod(50, 50);
        check("div100_valid_count", 32'(validCnt - v0), 3);
        check("div100_period",      lastPeriod, 100);
        check("div100_high",        lastHigh,   50);
        check("div100_divok",       32'(lastDivOk), 1);
        check("div100_gap",         32'(lastGap), 100);

        // Period 37, high 10.
        v0 = validCnt;
        sigPeriod(10, 27);
        sigPeriod(10, 27);
        sigPeriod(10, 27);
        check("p37_valid_count", 32'(validCnt - v0), 3);
        check("p37_period",      lastPeriod, 37);
        check("p37_high",        lastHigh,   10);
        check("p37_divok_level", 32'(divOk), 0);
        check("p37_gap",         32'(lastGap), 37);

        // Minimum period: toggle every cycle.
        v0 = validCnt;
        for (int i = 0; i < 6; i++) sigPeriod(1, 1);
        repeat (4) @(negedge clk);
        check("p2_valid_count", 32'(validCnt - v0), 6);
        check("p2_period",      lastPeriod, 2);
        check("p2_high",        lastHigh,   1);
        check("p2_gap",         32'(lastGap), 2);

        // Hold iSig low until the counter saturates.
        v0 = validCnt;
        repeat (200) @(negedge clk);
        check("tmo_not_yet", 32'(timeout), 0);
        repeat (80) @(negedge clk);
        check("tmo_set",          32'(timeout), 1);
        check("tmo_no_valid",     32'(validCnt - v0), 0);
        check("tmo_period_kept",  32'(period), 2);
        sigPeriod(50, 50);
        check("tmo_cleared",          32'(timeout), 0);
        check("tmo_rise_no_valid",    32'(validCnt - v0), 0);
        sigPeriod(50, 50);
        check("tmo_recover_valid",    32'(validCnt - v0), 1);
        check("tmo_recover_period",   lastPeriod, 100);
        check("tmo_recover_high",     lastHigh,   50);

        // Rise arrives exactly when the counter holds its maximum value.
        // The period is 256 cycles, so the result saturates at 255.
        v0 = validCnt;
        sigPeriod(128, 128);
        sigPeriod(50, 5);
        check("sat_valid_count", 32'(validCnt - v0), 2);
        check("sat_period",      lastPeriod, 255);
        check("sat_high",        lastHigh,   128);
        check("sat_gap",         32'(lastGap), 256);
        check("sat_no_timeout",  32'(timeout), 0);
        check("sat_divok",       32'(lastDivOk), 0);

        // Reset pulse at cnt=40 of a 100-cycle period (30 high, 70 low).
        sigPeriod(50, 50);
        sig = 1'b1;
        repeat (30) @(negedge clk);
        sig = 1'b0;
        repeat (13) @(negedge clk);
        check("prerst_period", 32'(period), 100);
        check("prerst_divok",  32'(divOk),  1);
        rstN = 1'b0;
        @(negedge clk);
        check("midrst_period",  32'(period),  0);
        check("midrst_high",    32'(high),    0);
        check("midrst_valid",   32'(valid),   0);
        check("midrst_divok",   32'(divOk),   0);
        check("midrst_timeout", 32'(timeout), 0);
        rstN = 1'b1;
        repeat (56) @(negedge clk);
        v0 = validCnt;
        sigPeriod(30, 70);
        check("postrst_first_rise_novalid", 32'(validCnt - v0), 0);

        // Second post-reset rise: check the exact latency and the pulse width.
        sig = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_valid_early", 32'(valid), 0);
        @(negedge clk);
        check("lat_valid_on",    32'(valid),  1);
        check("postrst_period",  32'(period), 100);
        check("postrst_high",    32'(high),   30);
        check("postrst_divok",   32'(divOk),  1);
        @(negedge clk);
        check("lat_valid_off",   32'(valid),  0);
        sig = 1'b0;
        repeat (5) @(negedge clk);
        check("valid_single_cycle", 32'(dupCnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_period_meter
`default_nettype wire
